// File: rtl/thunderbird_pkg.sv
// Shared types and constants for the Thunderbird tail-lamp monitor:
// mode encoding, FSM states, frame classes and lamp bit patterns.
package thunderbird_pkg;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    S_OFF,
    S_L1,
    S_L2,
    S_L3,
    S_R1,
    S_R2,
    S_R3,
    S_HZ,
    S_SYNC
  } state_e;

  typedef enum logic [3:0] {
    FR_DARK,
    FR_L1,
    FR_L2,
    FR_L3,
    FR_R1,
    FR_R2,
    FR_R3,
    FR_HZ,
    FR_ILLEGAL
  } frame_e;

  // Lamp patterns, bit0 = innermost lamp
  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_1   = 3'b001;
  localparam logic [2:0] LAMPS_2   = 3'b011;
  localparam logic [2:0] LAMPS_3   = 3'b111;

  localparam int unsigned TIMEOUT_DEFAULT = 8;
  localparam logic [7:0]  COUNT_MAX       = 8'hFF;

endpackage

// File: rtl/lamp_pattern_decode.sv
// Classifies one left/right lamp frame into the pattern classes the
// monitor FSM understands; anything outside the legal set is ILLEGAL.
module lamp_pattern_decode
  import thunderbird_pkg::*;
(
  input  logic [2:0] l_i,
  input  logic [2:0] r_i,
  output frame_e     frame_o
);

  // A frame is legal only if one side is dark, or both sides are fully lit
  always_comb begin
    frame_o = FR_ILLEGAL;
    if (r_i == LAMPS_OFF) begin
      case (l_i)
        LAMPS_OFF: frame_o = FR_DARK;
        LAMPS_1:   frame_o = FR_L1;
        LAMPS_2:   frame_o = FR_L2;
        LAMPS_3:   frame_o = FR_L3;
        default:   frame_o = FR_ILLEGAL;
      endcase
    end else if (l_i == LAMPS_OFF) begin
      case (r_i)
        LAMPS_1: frame_o = FR_R1;
        LAMPS_2: frame_o = FR_R2;
        LAMPS_3: frame_o = FR_R3;
        default: frame_o = FR_ILLEGAL;
      endcase
    end else if ((l_i == LAMPS_3) && (r_i == LAMPS_3)) begin
      frame_o = FR_HZ;
    end
  end

endmodule

// File: rtl/thunderbird_monitor.sv
// Watches sampled tail-lamp frames, decodes completed LEFT/RIGHT/HAZARD
// sequences, flags illegal frames and reverts to NONE after a dark timeout.
module thunderbird_monitor
  import thunderbird_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)
(
  input  logic       Clk,
  input  logic       reset,
  input  logic       frame_en,
  input  logic [2:0] L,
  input  logic [2:0] R,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       seq_err,
  output logic [7:0] seq_count
);

  localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

  state_e     state_q, state_d;
  mode_e      mode_q;
  logic       modeValid_q;
  logic       seqErr_q;
  logic [7:0] seqCount_q;
  logic [7:0] darkCount_q, darkCount_d;

  frame_e     frameClass;
  logic       complete;
  mode_e      completeMode;
  logic       frameErr;
  logic       darkStep;
  logic       timeoutHit;

  lamp_pattern_decode uDecode (
    .l_i     (L),
    .r_i     (R),
    .frame_o (frameClass)
  );

  // Next-state decision for one sampled frame; errors override the chain target
  always_comb begin
    state_d      = state_q;
    complete     = 1'b0;
    completeMode = MODE_NONE;
    frameErr     = 1'b0;
    darkStep     = 1'b0;
    case (state_q)
      S_OFF: begin
        case (frameClass)
          FR_DARK: darkStep = 1'b1;
          FR_L1:   state_d  = S_L1;
          FR_R1:   state_d  = S_R1;
          FR_HZ:   state_d  = S_HZ;
          default: frameErr = 1'b1;
        endcase
      end
      S_L1: if (frameClass == FR_L2) state_d = S_L2; else frameErr = 1'b1;
      S_L2: if (frameClass == FR_L3) state_d = S_L3; else frameErr = 1'b1;
      S_L3: begin
        if (frameClass == FR_DARK) begin
          state_d      = S_OFF;
          complete     = 1'b1;
          completeMode = MODE_LEFT;
        end else begin
          frameErr = 1'b1;
        end
      end
      S_R1: if (frameClass == FR_R2) state_d = S_R2; else frameErr = 1'b1;
      S_R2: if (frameClass == FR_R3) state_d = S_R3; else frameErr = 1'b1;
      S_R3: begin
        if (frameClass == FR_DARK) begin
          state_d      = S_OFF;
          complete     = 1'b1;
          completeMode = MODE_RIGHT;
        end else begin
          frameErr = 1'b1;
        end
      end
      S_HZ: begin
        if (frameClass == FR_DARK) begin
          state_d      = S_OFF;
          complete     = 1'b1;
          completeMode = MODE_HAZARD;
        end else begin
          frameErr = 1'b1;
        end
      end
      S_SYNC: if (frameClass == FR_DARK) state_d = S_OFF;
      default: state_d = S_OFF;
    endcase

    if (frameErr) begin
      state_d = (frameClass == FR_DARK) ? S_OFF : S_SYNC;
    end
  end

  // Dark count restarts at 1 whenever S_OFF is re-entered
  always_comb begin
    darkCount_d = darkCount_q;
    if ((state_d == S_OFF) && (state_q != S_OFF)) begin
      darkCount_d = 8'd1;
    end else if (darkStep && (darkCount_q != COUNT_MAX)) begin
      darkCount_d = darkCount_q + 8'd1;
    end
    timeoutHit = darkStep && (darkCount_d == TimeoutCount);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OFF;
      darkCount_q <= 8'd0;
      mode_q      <= MODE_NONE;
      modeValid_q <= 1'b0;
      seqErr_q    <= 1'b0;
      seqCount_q  <= 8'd0;
    end else begin
      seqErr_q <= 1'b0;
      if (frame_en) begin
        state_q     <= state_d;
        darkCount_q <= darkCount_d;
        if (frameErr) begin
          mode_q      <= MODE_NONE;
          modeValid_q <= 1'b0;
          seqErr_q    <= 1'b1;
        end else if (complete) begin
          mode_q      <= completeMode;
          modeValid_q <= 1'b1;
          if (seqCount_q != COUNT_MAX) begin
            seqCount_q <= seqCount_q + 8'd1;
          end
        end else if (timeoutHit) begin
          mode_q      <= MODE_NONE;
          modeValid_q <= 1'b1;
        end
      end
    end
  end

  assign mode       = mode_q;
  assign mode_valid = modeValid_q;
  assign seq_err    = seqErr_q;
  assign seq_count  = seqCount_q;

endmodule

// File: tb/tb_thunderbird_monitor.sv
// Scoreboard bench for thunderbird_monitor (TIMEOUT=4): directed frames push
// hand-computed expectations; a monitor pops them the cycle after each frame.
module tb_thunderbird_monitor;

  typedef struct packed {
    logic [1:0] mode;
    logic       valid;
    logic       err;
    logic [7:0] count;
  } exp_t;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_en = 1'b0;
  logic [2:0] L = 3'b000;
  logic [2:0] R = 3'b000;
  logic [1:0] mode;
  logic       mode_valid;
  logic       seq_err;
  logic [7:0] seq_count;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  lastExp = '0;
  logic  sampledEn;
  int    testsRun = 0;
  int    testsFailed = 0;

  always #5 Clk = ~Clk;

  thunderbird_monitor #(.TIMEOUT(4)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .frame_en   (frame_en),
    .L          (L),
    .R          (R),
    .mode       (mode),
    .mode_valid (mode_valid),
    .seq_err    (seq_err),
    .seq_count  (seq_count)
  );

  // Remember which cycles actually delivered a frame to the DUT
  always @(posedge Clk or posedge reset) begin
    if (reset) sampledEn <= 1'b0;
    else       sampledEn <= frame_en;
  end

  function automatic exp_t mk(input logic [1:0] m, input logic v, input logic e,
                              input logic [7:0] c);
    exp_t x;
    x.mode = m; x.valid = v; x.err = e; x.count = c;
    return x;
  endfunction

  task automatic checkOutput(input string name, input exp_t want);
    exp_t act;
    act = {mode, mode_valid, seq_err, seq_count};
    testsRun++;
    if (act !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got mode=%b valid=%b err=%b count=%0d, want mode=%b valid=%b err=%b count=%0d",
               name, act.mode, act.valid, act.err, act.count,
               want.mode, want.valid, want.err, want.count);
    end
  endtask

  // Monitor: frame cycles pop the scoreboard, idle cycles must hold with seq_err low
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge Clk);
      if (!reset) begin
        if (sampledEn) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: frame response with no expectation queued");
          end else begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput(n, e);
            lastExp = e;
          end
        end else begin
          e = lastExp;
          e.err = 1'b0;
          checkOutput("idle hold", e);
        end
      end
    end
  end

  // One frame strobe followed by an idle cycle with junk on the lamp inputs
  task automatic applyStimulus(input string name, input logic [2:0] l,
                               input logic [2:0] r, input exp_t want);
    @(negedge Clk);
    L = l;
    R = r;
    frame_en = 1'b1;
    expQ.push_back(want);
    nameQ.push_back(name);
    @(negedge Clk);
    frame_en = 1'b0;
    L = 3'($urandom);
    R = 3'($urandom);
  endtask

  task automatic applyReset(input logic withFrame, input logic [2:0] l, input logic [2:0] r);
    @(negedge Clk);
    #2;
    if (withFrame) begin
      L = l;
      R = r;
      frame_en = 1'b1;
    end
    reset = 1'b1;
    #1;
    checkOutput("reset async", '0);
    lastExp = '0;
    @(negedge Clk);
    #2;
    frame_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic printSummary();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
  endtask

  initial begin
    #1_000_000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    printSummary();
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t holdExp;
    applyReset(1'b0, 3'b000, 3'b000);

    // Left sequence, then dark frames up to the timeout
    applyStimulus("left L1", 3'b001, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("left L2", 3'b011, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("left L3", 3'b111, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("left done", 3'b000, 3'b000, mk(2'b01, 1'b1, 1'b0, 8'd1));
    applyStimulus("dark 2", 3'b000, 3'b000, mk(2'b01, 1'b1, 1'b0, 8'd1));
    applyStimulus("dark 3", 3'b000, 3'b000, mk(2'b01, 1'b1, 1'b0, 8'd1));
    applyStimulus("timeout", 3'b000, 3'b000, mk(2'b00, 1'b1, 1'b0, 8'd1));
    applyStimulus("post timeout", 3'b000, 3'b000, mk(2'b00, 1'b1, 1'b0, 8'd1));

    // Three hazard sequences from reset
    applyReset(1'b0, 3'b000, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      holdExp = (k == 1) ? mk(2'b00, 1'b0, 1'b0, 8'd0) : mk(2'b11, 1'b1, 1'b0, 8'(k - 1));
      applyStimulus("hazard lit", 3'b111, 3'b111, holdExp);
      applyStimulus("hazard done", 3'b000, 3'b000, mk(2'b11, 1'b1, 1'b0, 8'(k)));
    end

    // Illegal frame, resync without a second error, then a right sequence
    applyStimulus("illegal", 3'b010, 3'b000, mk(2'b00, 1'b0, 1'b1, 8'd3));
    applyStimulus("sync stay", 3'b011, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd3));
    applyStimulus("sync exit", 3'b000, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd3));
    applyStimulus("right R1", 3'b000, 3'b001, mk(2'b00, 1'b0, 1'b0, 8'd3));
    applyStimulus("right R2", 3'b000, 3'b011, mk(2'b00, 1'b0, 1'b0, 8'd3));
    applyStimulus("right R3", 3'b000, 3'b111, mk(2'b00, 1'b0, 1'b0, 8'd3));
    applyStimulus("right done", 3'b000, 3'b000, mk(2'b10, 1'b1, 1'b0, 8'd4));

    // Dark frame mid-chain is an error that lands straight in S_OFF
    applyStimulus("R1 again", 3'b000, 3'b001, mk(2'b10, 1'b1, 1'b0, 8'd4));
    applyStimulus("dark err", 3'b000, 3'b000, mk(2'b00, 1'b0, 1'b1, 8'd4));
    applyStimulus("dark err+2", 3'b000, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd4));
    applyStimulus("dark err+3", 3'b000, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd4));
    applyStimulus("timeout err", 3'b000, 3'b000, mk(2'b00, 1'b1, 1'b0, 8'd4));

    // Wrong lit frame mid-chain goes to S_SYNC
    applyStimulus("L1 again", 3'b001, 3'b000, mk(2'b00, 1'b1, 1'b0, 8'd4));
    applyStimulus("skip err", 3'b111, 3'b000, mk(2'b00, 1'b0, 1'b1, 8'd4));
    applyStimulus("sync hz", 3'b111, 3'b111, mk(2'b00, 1'b0, 1'b0, 8'd4));
    applyStimulus("sync out", 3'b000, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd4));

    // Reset in S_L2 with a concurrent L3 frame: partial sequence discarded
    applyStimulus("pre-rst L1", 3'b001, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd4));
    applyStimulus("pre-rst L2", 3'b011, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd4));
    applyReset(1'b1, 3'b111, 3'b000);
    applyStimulus("after rst dark", 3'b000, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("after rst L1", 3'b001, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("after rst L2", 3'b011, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("after rst L3", 3'b111, 3'b000, mk(2'b00, 1'b0, 1'b0, 8'd0));
    applyStimulus("after rst done", 3'b000, 3'b000, mk(2'b01, 1'b1, 1'b0, 8'd1));

    // Saturation of the sequence counter
    applyReset(1'b0, 3'b000, 3'b000);
    for (int i = 1; i <= 300; i++) begin
      holdExp = (i == 1) ? mk(2'b00, 1'b0, 1'b0, 8'd0)
                         : mk(2'b11, 1'b1, 1'b0, 8'((i - 1) > 255 ? 255 : (i - 1)));
      applyStimulus("sat lit", 3'b111, 3'b111, holdExp);
      applyStimulus("sat done", 3'b000, 3'b000, mk(2'b11, 1'b1, 1'b0, 8'(i > 255 ? 255 : i)));
    end

    repeat (3) @(negedge Clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    printSummary();
    $finish;
  end

endmodule
